// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer for the E stage.
// Accepts mult/multu/div/divu/mthi/mtlo from the decoder and owns HI/LO.
// A mult or div result is computed at issue. It is held in pending registers,
// then committed to HI/LO after a fixed busy interval. This models the latency
// of an iterative unit.
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   md_start, md_op   E-stage md op valid / opcode (1 mult, 2 multu, 3 div,
//                     4 divu, 5 mthi, 6 mtlo, 0/7 none)
//   rs_data, rt_data  forwarded operands
//   id_md_use         D-stage instruction touches the md unit
//   busy              registered, high while a mult/div is in flight
//   stall             combinational hold request for the D stage
//   hi, lo            architectural HI/LO registers
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          busy_next;
  logic [31:0]   hi_next, lo_next;
  logic [31:0]   pend_hi_reg, pend_hi_next, pend_lo_reg, pend_lo_next;

  // Opcode decode
  logic is_mult, is_multu, is_div, is_divu, is_run_op;
  assign is_mult   = (md_op == 3'd1);
  assign is_multu  = (md_op == 3'd2);
  assign is_div    = (md_op == 3'd3);
  assign is_divu   = (md_op == 3'd4);
  assign is_run_op = is_mult | is_multu | is_div | is_divu;

  // Products: operands are extended to 64 bits explicitly, so the multiply is
  // full width for both signed and unsigned forms.
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Division is done on magnitudes and the signs are fixed afterwards. The
  // quotient is negated when the operand signs differ. The remainder follows
  // the dividend's sign. 0x80000000 / -1 wraps naturally to 0x80000000, rem 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;
  assign a_neg = is_div & rs_data[31];
  assign b_neg = is_div & rt_data[31];
  assign a_mag = a_neg ? (32'd0 - rs_data) : rs_data;
  assign b_mag = b_neg ? (32'd0 - rt_data) : rt_data;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign div_q = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign div_r = a_neg ? (32'd0 - r_mag) : r_mag;

  // Result selected at issue (valid only when is_run_op)
  logic [31:0] res_hi, res_lo;
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_mult) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (is_multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (rt_data == 32'd0) begin
      // Divide by zero: all-ones quotient, dividend passed through as remainder
      res_hi = rs_data;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = div_r;
      res_lo = div_q;
    end
  end

  // The issue term is included because busy only rises after the issue edge.
  assign stall = id_md_use & (busy | (md_start & is_run_op));

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    busy_next    = busy;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    case (state_reg)
      IDLE: begin
        if (md_start) begin
          if (is_run_op) begin
            pend_hi_next = res_hi;
            pend_lo_next = res_lo;
            count_next   = (is_mult | is_multu) ? MULT_LOAD : DIV_LOAD;
            busy_next    = 1'b1;
            state_next   = RUN;
          end else if (md_op == 3'd5) begin
            hi_next = rs_data;
          end else if (md_op == 3'd6) begin
            lo_next = rs_data;
          end
        end
      end
      RUN: begin
        // Any md_start here is ignored; the running op is left undisturbed.
        if (count_reg == '0) begin
          hi_next    = pend_hi_reg;
          lo_next    = pend_lo_reg;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      busy        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      busy        <= busy_next;
      hi          <= hi_next;
      lo          <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
    end
  end

endmodule
